// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl
//   I2C target (slave) controller. Oversamples SCL/SDA on clk, detects
//   START / repeated START / STOP, matches a 7-bit address, ACKs it, then
//   receives bytes for the fabric (master write) or shifts out fabric-supplied
//   bytes (master read). SDA is only ever pulled low (open-drain); SCL is
//   never driven.
// Ports:
//   clk, rst      system clock (>= 8x SCL), async active-high reset
//   scl_in/sda_in raw bus pin levels
//   sda_oe        1 = pull SDA low
//   rx_data       last received byte, rx_valid pulses when it updates
//   tx_data       byte to send, captured in the cycle tx_req pulses
//   addr_hit      address matched, until STOP / repeated START
//   rw            R/W bit of last matched address (1 = read)
//   state_target  FSM state for debug, busy = state not IDLE
module i2c_target_ctrl #(
  parameter int unsigned         ADDR_LEN    = 7,
  parameter int unsigned         DATA_LEN    = 8,
  parameter logic [ADDR_LEN-1:0] TARGET_ADDR = 7'h50,
  parameter int unsigned         SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scl_in,
  input  logic                sda_in,
  output logic                sda_oe,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  input  logic [DATA_LEN-1:0] tx_data,
  output logic                tx_req,
  output logic                addr_hit,
  output logic                rw,
  output logic [2:0]          state_target,
  output logic                busy
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_RX_BYTE   = 3'd3,
    ST_RX_ACK    = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_e;

  localparam logic [3:0] LAST_BIT = 4'(DATA_LEN);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_dly_q, sda_dly_q;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_LEN-1:0]    shift_q, shift_d;
  logic                   sda_oe_q, sda_oe_d;
  logic [DATA_LEN-1:0]    rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   addr_hit_q, addr_hit_d;
  logic                   rw_q, rw_d;
  logic                   ack_q, ack_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_evt, stop_evt;
  logic addr_match;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise   = scl_s & ~scl_dly_q;
  assign scl_fall   = ~scl_s & scl_dly_q;
  assign start_evt  = scl_s & ~sda_s & sda_dly_q;
  assign stop_evt   = scl_s & sda_s & ~sda_dly_q;
  assign addr_match = (shift_q[DATA_LEN-1 -: ADDR_LEN] == TARGET_ADDR);

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
  end

  // State register and all datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      addr_hit_q <= 1'b0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      addr_hit_q <= addr_hit_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
    end
  end

  // Next-state logic; bus events take priority over bit processing.
  always_comb begin
    state_d = state_q;
    if (stop_evt) begin
      state_d = ST_IDLE;
    end else if (start_evt) begin
      state_d = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE:      state_d = ST_IDLE;
        ST_ADDR:
          if (scl_fall && bit_cnt_q == LAST_BIT)
            state_d = addr_match ? ST_ADDR_ACK : ST_WAIT_STOP;
        ST_ADDR_ACK:
          if (scl_fall) state_d = rw_q ? ST_TX_BYTE : ST_RX_BYTE;
        ST_RX_BYTE:
          if (scl_fall && bit_cnt_q == LAST_BIT) state_d = ST_RX_ACK;
        ST_RX_ACK:
          if (scl_fall) state_d = ST_RX_BYTE;
        ST_TX_BYTE:
          if (scl_fall && bit_cnt_q == LAST_BIT) state_d = ST_TX_ACK;
        ST_TX_ACK:
          if (scl_fall) state_d = ack_q ? ST_WAIT_STOP : ST_TX_BYTE;
        ST_WAIT_STOP: state_d = ST_WAIT_STOP;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Output / datapath logic.
  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    addr_hit_d = addr_hit_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    tx_req     = 1'b0;
    if (stop_evt || start_evt) begin
      bit_cnt_d  = '0;
      sda_oe_d   = 1'b0;
      addr_hit_d = 1'b0;
    end else begin
      // Counter saturates at the ACK slot and is cleared on the ACK slot's fall.
      if (scl_rise && state_q != ST_IDLE && bit_cnt_q != LAST_BIT)
        bit_cnt_d = bit_cnt_q + 4'd1;
      unique case (state_q)
        ST_ADDR: begin
          if (scl_rise) shift_d = {shift_q[DATA_LEN-2:0], sda_s};
          if (scl_fall && bit_cnt_q == LAST_BIT) begin
            if (addr_match) begin
              sda_oe_d = 1'b1;
              rw_d     = shift_q[0];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            addr_hit_d = 1'b1;
            bit_cnt_d  = '0;
            if (rw_q) begin
              tx_req   = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[DATA_LEN-1];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_RX_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[DATA_LEN-2:0], sda_s};
            if (bit_cnt_q == LAST_BIT - 4'd1) begin
              rx_data_d  = {shift_q[DATA_LEN-2:0], sda_s};
              rx_valid_d = 1'b1;
            end
          end
          if (scl_fall && bit_cnt_q == LAST_BIT) sda_oe_d = 1'b1;
        end
        ST_RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
          end
        end
        ST_TX_BYTE: begin
          // MSB went out on entry; each later fall presents the next bit.
          if (scl_fall && bit_cnt_q != 4'd0) begin
            if (bit_cnt_q == LAST_BIT) begin
              sda_oe_d = 1'b0;
            end else begin
              shift_d  = {shift_q[DATA_LEN-2:0], 1'b0};
              sda_oe_d = ~shift_q[DATA_LEN-2];
            end
          end
        end
        ST_TX_ACK: begin
          if (scl_rise) ack_d = sda_s;
          if (scl_fall) begin
            bit_cnt_d = '0;
            if (!ack_q) begin
              tx_req   = 1'b1;
              shift_d  = tx_data;
              sda_oe_d = ~tx_data[DATA_LEN-1];
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        ST_WAIT_STOP: sda_oe_d = 1'b0;
        default: ;
      endcase
    end
  end

  assign sda_oe       = sda_oe_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign addr_hit     = addr_hit_q;
  assign rw           = rw_q;
  assign state_target = state_q;
  assign busy         = (state_q != ST_IDLE);

endmodule
